instr_queue: RTL and testbench
==============================

# instr_queue

Parametrised instruction register with a first-word-fall-through prefetch queue. It sits between program memory and the control sequencer. Memory pushes instruction words while the sequencer is still busy, so the fetch phase overlaps execution. Each queued word is presented split into opcode and operand fields, with a valid/ready issue handshake and a synchronous flush for jumps.

## Interface
- DATA_W, 8, instruction word width in bits
- OPCODE_W, 4, width of the opcode field (upper bits of the word); operand is the remaining DATA_W-OPCODE_W bits
- DEPTH, 4, queue entries; must be a power of two, ≥2
- HALT_OPCODE, 4'hF, opcode treated as halt (used only with INSTR_QUEUE_HALT_EN)

Ports:
- clk  in  1  main clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- load  in  1  push request from memory (Eir-style enable)
- load_data  in  DATA_W  instruction word from memory
- full  out  1  queue holds DEPTH entries
- issue_valid  out  1  head entry available to sequencer
- issue_ready  in  1  sequencer accepts head entry
- opcode  out  OPCODE_W  head word upper field; 0 when issue_valid=0
- operand  out  DATA_W-OPCODE_W  head word lower field; 0 when issue_valid=0
- count  out  $clog2(DEPTH)+1  entries currently held
- flush  in  1  synchronous discard of all entries
- overflow  out  1  sticky: a load was dropped
- halted  out  1  halt instruction issued (0 when feature compiled out)

## Operation
- Storage: DEPTH×DATA_W array, write/read pointers of $clog2(DEPTH)+1 bits with wrap bit; empty when equal, full when MSBs differ and the rest are equal.
- pop = issue_valid & issue_ready.
- push = load & (!full | pop). Loading while full with a simultaneous pop is accepted.
- load & full & !pop: word dropped, overflow←1, contents unchanged.
- Simultaneous push and pop: count unchanged, both pointers advance.
- flush (highest priority): pointers, count, overflow and halted cleared next edge. Same-cycle load and pop are ignored.
- First-word-fall-through: head entry drives opcode/operand combinationally from storage whenever issue_valid=1.
- issue_valid = !empty & !halted.
- Pointer wrap: the low bits wrap modulo DEPTH and the wrap bit toggles. No entry is lost across a wrap.
- Storage array is not reset; only pointers and flags are.

## Timing
- Reset (rst_n=0, async): count=0, full=0, issue_valid=0, opcode=0, operand=0, overflow=0, halted=0.
- Push-to-issue latency: word loaded at edge N is visible on opcode/operand with issue_valid=1 after edge N (1 cycle). There is no same-cycle bypass.
- Pop takes effect at the edge where issue_valid&issue_ready; the next entry appears immediately after that edge.
- count, full and overflow are registered and update on the same edge as the pointers.
- rst_n asserted mid-operation drops all entries immediately, regardless of clk.

## Configuration
- INSTR_QUEUE_HALT_EN defined:
  - When a pop occurs with opcode==HALT_OPCODE, halted←1 at that edge.
  - While halted, issue_valid=0 and opcode/operand=0. load is still accepted.
  - halted is cleared only by flush or rst_n.
- INSTR_QUEUE_HALT_EN undefined: halted tied 0, and HALT_OPCODE is issued like any other instruction.

## Structure
- Package instr_queue_pkg:
  - default DATA_W/OPCODE_W/DEPTH constants
  - HALT_OPCODE default
  - count-width function ($clog2(DEPTH)+1)
  - opcode/operand field-slice helpers shared with the sequencer decoder
- Single module. No sub-module is needed; the pointer logic is two small registers inline.

## Test plan
- Reset then push 8'h1A, 8'h2B with issue_ready=0 → count=2, opcode=4'h1, operand=4'hA. Raise ready for 2 cycles → 4'h2/4'hB issued, then issue_valid=0, count=0.
- Push 5 words (DEPTH=4) with ready=0 → full=1 after 4th push, 5th dropped, overflow=1. Pop 4 → original 4 words in order.
- Full queue, load=1 & issue_ready=1 same cycle → count stays 4, new word issued 4 pops later, overflow=0.
- Queue holding 3 entries, assert flush together with load and issue_ready → next cycle count=0, issue_valid=0, overflow=0, no word accepted.
- With INSTR_QUEUE_HALT_EN: push 8'hF0, 8'h35, ready=1 → 8'hF0 issued, halted=1, issue_valid=0 with count=1. Flush → halted=0. Without the macro, 8'h35 issues next cycle.
- Assert rst_n=0 between clock edges with queue half full → all outputs 0 immediately. Run 3·DEPTH push/pop cycles across pointer wrap → order preserved.

Source files
------------

// File: rtl/instr_queue_pkg.sv
// Shared constants and field helpers for the instruction prefetch queue
// and the sequencer decoder that consumes its output.
package instr_queue_pkg;

    localparam int              DATA_W_DEF      = 8;
    localparam int              OPCODE_W_DEF    = 4;
    localparam int              DEPTH_DEF       = 4;
    localparam logic [3:0]      HALT_OPCODE_DEF = 4'hF;

    // Pointer/count width: one extra bit beyond the index carries the wrap flag.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Upper field of a default-width instruction word.
    function automatic logic [OPCODE_W_DEF-1:0] opcode_of(input logic [DATA_W_DEF-1:0] word);
        return word[DATA_W_DEF-1 -: OPCODE_W_DEF];
    endfunction

    // Lower field of a default-width instruction word.
    function automatic logic [DATA_W_DEF-OPCODE_W_DEF-1:0] operand_of(input logic [DATA_W_DEF-1:0] word);
        return word[DATA_W_DEF-OPCODE_W_DEF-1:0];
    endfunction

endpackage

// File: rtl/instr_queue_if.sv
// Memory-side push bus plus sequencer-side issue handshake of the
// instruction queue. master = memory/sequencer side, slave = the queue.
interface instr_queue_if
    import instr_queue_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int OPCODE_W = OPCODE_W_DEF,
    parameter int DEPTH    = DEPTH_DEF
);
    localparam int CNT_W = cnt_w(DEPTH);

    logic                       load;
    logic [DATA_W-1:0]          load_data;
    logic                       full;
    logic                       issue_valid;
    logic                       issue_ready;
    logic [OPCODE_W-1:0]        opcode;
    logic [DATA_W-OPCODE_W-1:0] operand;
    logic [CNT_W-1:0]           count;
    logic                       flush;
    logic                       overflow;
    logic                       halted;

    modport master (
        output load, load_data, issue_ready, flush,
        input  full, issue_valid, opcode, operand, count, overflow, halted
    );

    modport slave (
        input  load, load_data, issue_ready, flush,
        output full, issue_valid, opcode, operand, count, overflow, halted
    );

endinterface

// File: rtl/instr_queue.sv
// First-word-fall-through instruction prefetch queue. The head word is
// presented split into opcode/operand with a valid/ready issue handshake;
// flush discards everything for jumps.
// Optional feature: define INSTR_QUEUE_HALT_EN to stop issuing after a
// HALT_OPCODE instruction has been popped (cleared by flush or reset).
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int                  DATA_W      = DATA_W_DEF,
    parameter int                  OPCODE_W    = OPCODE_W_DEF,
    parameter int                  DEPTH       = DEPTH_DEF,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF
)(
    input  logic          clk,
    input  logic          rst_n,
    instr_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    // Storage is deliberately not reset; only pointers and flags are.
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [CW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_full;
    logic              r_overflow;

    logic              w_empty;
    logic              w_valid;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_halted;
    logic [DATA_W-1:0] w_head;
    logic [CW-1:0]     w_wr_next;
    logic [CW-1:0]     w_rd_next;
    logic [CW-1:0]     w_count_next;
    logic              w_full_next;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_valid = !w_empty && !w_halted;
    assign w_pop   = w_valid && bus.issue_ready;
    // A full queue still accepts a word when the head leaves in the same cycle.
    assign w_push  = bus.load && (!r_full || w_pop);
    assign w_drop  = bus.load && r_full && !w_pop;
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    assign w_wr_next    = r_wr_ptr + CW'(w_push);
    assign w_rd_next    = r_rd_ptr + CW'(w_pop);
    assign w_count_next = w_wr_next - w_rd_next;
    assign w_full_next  = (w_wr_next[CW-1] != w_rd_next[CW-1]) &&
                          (w_wr_next[AW-1:0] == w_rd_next[AW-1:0]);

    // Pointer, occupancy and sticky-overflow registers; flush beats load/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (bus.flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            r_full   <= w_full_next;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Write the incoming word at the tail slot when it is accepted.
    always_ff @(posedge clk) begin
        if (w_push && !bus.flush) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bus.load_data;
        end
    end

`ifdef INSTR_QUEUE_HALT_EN
    logic r_halted;

    // Latch halt when the halt instruction is handed to the sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halted <= 1'b0;
        end else if (bus.flush) begin
            r_halted <= 1'b0;
        end else if (w_pop && (w_head[DATA_W-1 -: OPCODE_W] == HALT_OPCODE)) begin
            r_halted <= 1'b1;
        end
    end

    assign w_halted = r_halted;
`else
    logic w_unused_halt;
    assign w_unused_halt = ^HALT_OPCODE;
    assign w_halted      = 1'b0;
`endif

    assign bus.full        = r_full;
    assign bus.count       = r_count;
    assign bus.overflow    = r_overflow;
    assign bus.halted      = w_halted;
    assign bus.issue_valid = w_valid;
    assign bus.opcode      = w_valid ? w_head[DATA_W-1 -: OPCODE_W] : '0;
    assign bus.operand     = w_valid ? w_head[DATA_W-OPCODE_W-1:0]  : '0;

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue against a queue-based reference model.
module tb_instr_queue;
    import instr_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int VW    = 15;
`ifdef INSTR_QUEUE_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    logic [7:0] mq [$];
    bit         m_ovf;
    bit         m_halt;

    instr_queue_if #(.DATA_W(8), .OPCODE_W(4), .DEPTH(DEPTH)) q_if ();

    instr_queue #(.DATA_W(8), .OPCODE_W(4), .DEPTH(DEPTH), .HALT_OPCODE(4'hF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (q_if.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [VW-1:0] obs_vec();
        return {q_if.count, q_if.full, q_if.issue_valid, q_if.opcode, q_if.operand,
                q_if.overflow, q_if.halted};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [2:0] c;
        bit         v;
        logic [7:0] h;
        c = 3'(mq.size());
        v = (mq.size() > 0) && !m_halt;
        h = v ? mq[0] : 8'h00;
        return {c, (mq.size() == DEPTH), v, opcode_of(h), operand_of(h), m_ovf, m_halt};
    endfunction

    function automatic void model_clear();
        mq.delete();
        m_ovf  = 1'b0;
        m_halt = 1'b0;
    endfunction

    // Drive one clock cycle of stimulus and advance the model by the same edge.
    task automatic cycle(input bit ld, input logic [7:0] d, input bit rdy, input bit fl);
        bit         v;
        bit         pop;
        bit         full;
        logic [7:0] head;
        q_if.load        = ld;
        q_if.load_data   = d;
        q_if.issue_ready = rdy;
        q_if.flush       = fl;
        @(posedge clk);
        #1;
        if (fl) begin
            model_clear();
        end else begin
            v    = (mq.size() > 0) && !m_halt;
            pop  = v && rdy;
            full = (mq.size() == DEPTH);
            head = v ? mq[0] : 8'h00;
            if (pop) begin
                void'(mq.pop_front());
                if (HALT_EN && head[7:4] == 4'hF) m_halt = 1'b1;
            end
            if (ld && (!full || pop)) mq.push_back(d);
            if (ld && full && !pop) m_ovf = 1'b1;
        end
        $display("cyc ld=%0b d=%02h rdy=%0b fl=%0b -> cnt=%0d full=%0b v=%0b op=%h opd=%h ovf=%0b hlt=%0b",
                 ld, d, rdy, fl, q_if.count, q_if.full, q_if.issue_valid, q_if.opcode,
                 q_if.operand, q_if.overflow, q_if.halted);
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        q_if.load        = 1'b0;
        q_if.load_data   = 8'h00;
        q_if.issue_ready = 1'b0;
        q_if.flush       = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_vec() !== {VW{1'b0}}) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs_vec(), {VW{1'b0}});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        cycle(1, 8'h1A, 0, 0);
        cycle(1, 8'h2B, 0, 0);
        checks++;
        if ({q_if.count, q_if.opcode, q_if.operand} !== {3'd2, 4'h1, 4'hA}) begin
            errors++;
            $display("FAIL basic_two_queued: got cnt=%0d %h/%h want 2 1/a", q_if.count, q_if.opcode, q_if.operand);
        end
        cycle(0, 8'h00, 1, 0);
        checks++;
        if ({q_if.issue_valid, q_if.opcode, q_if.operand} !== {1'b1, 4'h2, 4'hB}) begin
            errors++;
            $display("FAIL basic_second_head: got v=%0b %h/%h want 1 2/b", q_if.issue_valid, q_if.opcode, q_if.operand);
        end
        cycle(0, 8'h00, 1, 0);
        checks++;
        if (obs_vec() !== exp_vec() || q_if.issue_valid !== 1'b0 || q_if.count !== 3'd0) begin
            errors++;
            $display("FAIL basic_drained: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_overflow();
        logic [7:0] words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) begin
            cycle(1, words[i], 0, 0);
            if (i == 3) begin
                checks++;
                if ({q_if.full, q_if.overflow} !== 2'b10) begin
                    errors++;
                    $display("FAIL ovf_full_after_4: got full=%0b ovf=%0b want 1 0", q_if.full, q_if.overflow);
                end
            end
        end
        checks++;
        if ({q_if.count, q_if.overflow} !== {3'd4, 1'b1}) begin
            errors++;
            $display("FAIL ovf_dropped: got cnt=%0d ovf=%0b want 4 1", q_if.count, q_if.overflow);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({q_if.issue_valid, q_if.opcode, q_if.operand} !== {1'b1, words[i]}) begin
                errors++;
                $display("FAIL ovf_order[%0d]: got v=%0b %h%h want 1 %h", i, q_if.issue_valid,
                         q_if.opcode, q_if.operand, words[i]);
            end
            cycle(0, 8'h00, 1, 0);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL ovf_drained: got %h want %h", obs_vec(), exp_vec());
        end
        cycle(0, 8'h00, 0, 1);
    endtask

    task automatic test_full_pushpop();
        logic [7:0] heads [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hC7};
        for (int i = 0; i < 4; i++) cycle(1, 8'hA0 + 8'(i), 0, 0);
        cycle(1, 8'hC7, 1, 0);
        checks++;
        if ({q_if.count, q_if.full, q_if.overflow} !== {3'd4, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL full_pushpop_cnt: got cnt=%0d full=%0b ovf=%0b want 4 1 0",
                     q_if.count, q_if.full, q_if.overflow);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({q_if.opcode, q_if.operand} !== heads[i]) begin
                errors++;
                $display("FAIL full_pushpop_order[%0d]: got %h%h want %h", i, q_if.opcode, q_if.operand, heads[i]);
            end
            cycle(0, 8'h00, 1, 0);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) cycle(1, 8'h61 + 8'(i), 0, 0);
        cycle(1, 8'h99, 1, 1);
        checks++;
        if ({q_if.count, q_if.issue_valid, q_if.overflow} !== 5'b0) begin
            errors++;
            $display("FAIL flush_clear: got cnt=%0d v=%0b ovf=%0b want 0 0 0",
                     q_if.count, q_if.issue_valid, q_if.overflow);
        end
        cycle(0, 8'h00, 0, 0);
        checks++;
        if (obs_vec() !== {VW{1'b0}}) begin
            errors++;
            $display("FAIL flush_no_accept: got %h want 0", obs_vec());
        end
    endtask

    task automatic test_halt();
        cycle(1, 8'hF0, 0, 0);
        cycle(1, 8'h35, 0, 0);
        cycle(0, 8'h00, 1, 0);
        checks++;
        if ({q_if.halted, q_if.issue_valid, q_if.count, q_if.opcode, q_if.operand} !==
            {HALT_EN, !HALT_EN, 3'd1, (HALT_EN ? 8'h00 : 8'h35)}) begin
            errors++;
            $display("FAIL halt_after_f0: got hlt=%0b v=%0b cnt=%0d %h%h", q_if.halted,
                     q_if.issue_valid, q_if.count, q_if.opcode, q_if.operand);
        end
        cycle(0, 8'h00, 1, 0);
        checks++;
        if (q_if.count !== (HALT_EN ? 3'd1 : 3'd0) || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL halt_hold: got %h want %h", obs_vec(), exp_vec());
        end
        cycle(0, 8'h00, 0, 1);
        checks++;
        if (obs_vec() !== {VW{1'b0}}) begin
            errors++;
            $display("FAIL halt_flush: got %h want 0", obs_vec());
        end
    endtask

    task automatic test_async_reset();
        cycle(1, 8'h71, 0, 0);
        cycle(1, 8'h72, 0, 0);
        q_if.load = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        model_clear();
        checks++;
        if (obs_vec() !== {VW{1'b0}}) begin
            errors++;
            $display("FAIL async_reset_immediate: got %h want 0", obs_vec());
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL async_reset_held: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_wrap();
        cycle(1, 8'h40, 0, 0);
        for (int i = 1; i <= 3 * DEPTH; i++) begin
            cycle(1, 8'h40 + 8'(i), 1, 0);
            checks++;
            if (obs_vec() !== exp_vec() || {q_if.opcode, q_if.operand} !== 8'h40 + 8'(i)) begin
                errors++;
                $display("FAIL wrap_order[%0d]: got %h%h want %h", i, q_if.opcode, q_if.operand, 8'h40 + 8'(i));
            end
        end
        cycle(0, 8'h00, 0, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 19) == 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pushpop();
        test_flush();
        test_halt();
        test_async_reset();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
